// File: rtl/multi_cycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multi_cycle_ctrl
//  Description : Moore control FSM for the multi-cycle MIPS datapath; drives
//                enables and MUX selects, counts retired instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_cycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [5:0]       op_i,
    input  logic [5:0]       funct_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             ir_write_o,
    output logic             iord_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             reg_write_o,
    output logic [1:0]       reg_dst_o,
    output logic [1:0]       mem_to_reg_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [2:0]       alu_op_o,
    output logic [1:0]       pc_source_o,
    output logic [3:0]       state_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] retired_o
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_EXE_R   = 4'd3,
        S_WB_R    = 4'd4,
        S_EXE_I   = 4'd5,
        S_WB_I    = 4'd6,
        S_MEM_ADR = 4'd7,
        S_MEM_RD  = 4'd8,
        S_WB_LW   = 4'd9,
        S_MEM_WR  = 4'd10,
        S_BRANCH  = 4'd11,
        S_JUMP    = 4'd12,
        S_JAL     = 4'd13,
        S_JR      = 4'd14
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_SLTI  = 6'h0A;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;
    localparam logic [5:0] c_FN_JR    = 6'h08;

    // fetch_hs / br_en mark outputs that are qualified combinationally by
    // mem_ready_i or zero_i; everything else is a pure function of state.
    typedef struct packed {
        logic       fetch_hs;
        logic       br_en;
        logic       br_inv;
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    function automatic ctrl_t ctrl_for(input state_t s, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.fetch_hs  = 1'b1;
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            S_DECODE: c.alu_src_b = 2'b11;
            S_EXE_R: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 3'b010;
            end
            S_WB_R: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 2'b01;
            end
            S_EXE_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = (op == c_OP_SLTI) ? 3'b011 : 3'b000;
            end
            S_WB_I:  c.reg_write = 1'b1;
            S_MEM_ADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_WB_LW: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 2'b01;
            end
            S_MEM_WR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_BRANCH: begin
                c.br_en     = 1'b1;
                c.br_inv    = (op == c_OP_BNE);
                c.alu_src_a = 1'b1;
                c.alu_op    = 3'b001;
                c.pc_source = 2'b01;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            S_JAL: begin
                c.pc_write   = 1'b1;
                c.pc_source  = 2'b10;
                c.reg_write  = 1'b1;
                c.reg_dst    = 2'b10;
                c.mem_to_reg = 2'b10;
            end
            S_JR: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b11;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t           r_state;
    ctrl_t            r_ctrl;
    logic             r_illegal;
    logic [CNT_W-1:0] r_retired;

    state_t           w_next;
    logic             w_bad_op;
    logic             w_retire;

    always_comb begin
        w_next   = r_state;
        w_bad_op = 1'b0;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH:  if (mem_ready_i) w_next = S_DECODE;
            S_DECODE: begin
                case (op_i)
                    c_OP_RTYPE: w_next = (funct_i == c_FN_JR) ? S_JR : S_EXE_R;
                    c_OP_ADDI,
                    c_OP_SLTI:  w_next = S_EXE_I;
                    c_OP_LW,
                    c_OP_SW:    w_next = S_MEM_ADR;
                    c_OP_BEQ,
                    c_OP_BNE:   w_next = S_BRANCH;
                    c_OP_J:     w_next = S_JUMP;
                    c_OP_JAL:   w_next = S_JAL;
                    default: begin
                        w_next   = S_FETCH;
                        w_bad_op = 1'b1;
                    end
                endcase
            end
            S_EXE_R:   w_next = S_WB_R;
            S_WB_R:    w_next = S_FETCH;
            S_EXE_I:   w_next = S_WB_I;
            S_WB_I:    w_next = S_FETCH;
            S_MEM_ADR: w_next = (op_i == c_OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:  if (mem_ready_i) w_next = S_WB_LW;
            S_WB_LW:   w_next = S_FETCH;
            S_MEM_WR:  if (mem_ready_i) w_next = S_FETCH;
            S_BRANCH,
            S_JUMP,
            S_JAL,
            S_JR:      w_next = S_FETCH;
            default:   w_next = S_IDLE;
        endcase
    end

    // A FETCH->FETCH wait is not a transition, so it must not retire.
    assign w_retire = (w_next == S_FETCH) && (r_state != S_IDLE) &&
                      (r_state != S_FETCH) && !w_bad_op;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= S_IDLE;
            r_ctrl    <= '0;
            r_illegal <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= ctrl_for(w_next, op_i);
            if (w_bad_op)
                r_illegal <= 1'b1;
            if (w_retire)
                r_retired <= r_retired + 1'b1;
        end
    end

    assign pc_write_o   = r_ctrl.pc_write
                        | (r_ctrl.fetch_hs & mem_ready_i)
                        | (r_ctrl.br_en & (zero_i ^ r_ctrl.br_inv));
    assign ir_write_o   = r_ctrl.fetch_hs & mem_ready_i;
    assign iord_o       = r_ctrl.iord;
    assign mem_read_o   = r_ctrl.mem_read;
    assign mem_write_o  = r_ctrl.mem_write;
    assign reg_write_o  = r_ctrl.reg_write;
    assign reg_dst_o    = r_ctrl.reg_dst;
    assign mem_to_reg_o = r_ctrl.mem_to_reg;
    assign alu_src_a_o  = r_ctrl.alu_src_a;
    assign alu_src_b_o  = r_ctrl.alu_src_b;
    assign alu_op_o     = r_ctrl.alu_op;
    assign pc_source_o  = r_ctrl.pc_source;
    assign state_o      = r_state;
    assign illegal_o    = r_illegal;
    assign retired_o    = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_cycle_ctrl
//  Description : Directed-vector scoreboard bench for multi_cycle_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_cycle_ctrl;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       irw;
        logic       iord;
        logic       mr;
        logic       mw;
        logic       rw;
        logic [1:0] rd;
        logic [1:0] m2r;
        logic       asa;
        logic [1:0] asb;
        logic [2:0] aop;
        logic [1:0] pcs;
    } ctl_t;

    typedef struct packed {
        ctl_t        c;
        logic        ill;
        logic [31:0] ret;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic [5:0]  op_i = '0;
    logic [5:0]  funct_i = '0;
    logic        zero_i = 1'b0;
    logic        mem_ready_i = 1'b0;
    logic        pc_write_o, ir_write_o, iord_o, mem_read_o, mem_write_o;
    logic        reg_write_o, alu_src_a_o, illegal_o;
    logic [1:0]  reg_dst_o, mem_to_reg_o, alu_src_b_o, pc_source_o;
    logic [2:0]  alu_op_o;
    logic [3:0]  state_o;
    logic [31:0] retired_o;

    rec_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    multi_cycle_ctrl #(.CNT_W(32)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .op_i         (op_i),
        .funct_i      (funct_i),
        .zero_i       (zero_i),
        .mem_ready_i  (mem_ready_i),
        .pc_write_o   (pc_write_o),
        .ir_write_o   (ir_write_o),
        .iord_o       (iord_o),
        .mem_read_o   (mem_read_o),
        .mem_write_o  (mem_write_o),
        .reg_write_o  (reg_write_o),
        .reg_dst_o    (reg_dst_o),
        .mem_to_reg_o (mem_to_reg_o),
        .alu_src_a_o  (alu_src_a_o),
        .alu_src_b_o  (alu_src_b_o),
        .alu_op_o     (alu_op_o),
        .pc_source_o  (pc_source_o),
        .state_o      (state_o),
        .illegal_o    (illegal_o),
        .retired_o    (retired_o)
    );

    always #5 clk = ~clk;

    function automatic ctl_t mk(input logic [3:0] st, input logic pcw, input logic irw,
                                input logic iord, input logic mr, input logic mw,
                                input logic rw, input logic [1:0] rd, input logic [1:0] m2r,
                                input logic asa, input logic [1:0] asb,
                                input logic [2:0] aop, input logic [1:0] pcs);
        ctl_t c;
        c = {st, pcw, irw, iord, mr, mw, rw, rd, m2r, asa, asb, aop, pcs};
        return c;
    endfunction

    // Hand-written per-state expectations
    ctl_t E_IDLE, E_FETCH, E_FWAIT, E_DEC, E_EXR, E_WBR, E_ADDI, E_SLTI, E_WBI;
    ctl_t E_MADR, E_MRD, E_WBLW, E_MWR, E_BRT, E_BRN, E_JMP, E_JAL, E_JR;

    // One cycle of stimulus: drive inputs just after the edge, queue expectation.
    task automatic cyc(input string nm, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy, input logic rst,
                       input ctl_t c, input logic ill, input logic [31:0] ret);
        rec_t r;
        @(posedge clk);
        #1;
        op_i        = op;
        funct_i     = fn;
        zero_i      = z;
        mem_ready_i = rdy;
        rst_i       = rst;
        r.c   = c;
        r.ill = ill;
        r.ret = ret;
        exp_q.push_back(r);
        name_q.push_back(nm);
    endtask

    // Monitor: compares whatever the DUT presents against the oldest entry.
    initial begin
        rec_t  obs, e;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                obs.c = {state_o, pc_write_o, ir_write_o, iord_o, mem_read_o,
                         mem_write_o, reg_write_o, reg_dst_o, mem_to_reg_o,
                         alu_src_a_o, alu_src_b_o, alu_op_o, pc_source_o};
                obs.ill = illegal_o;
                obs.ret = retired_o;
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL %s: got state=%0d ctl=%h ill=%b ret=%0d, required state=%0d ctl=%h ill=%b ret=%0d",
                             nm, obs.c.st, obs.c, obs.ill, obs.ret, e.c.st, e.c, e.ill, e.ret);
                end
            end
        end
    end

    initial begin
        E_IDLE  = '0;
        E_FETCH = mk(4'd1,  1,1,0,1,0,0, 2'b00,2'b00, 0,2'b01,3'b000,2'b00);
        E_FWAIT = mk(4'd1,  0,0,0,1,0,0, 2'b00,2'b00, 0,2'b01,3'b000,2'b00);
        E_DEC   = mk(4'd2,  0,0,0,0,0,0, 2'b00,2'b00, 0,2'b11,3'b000,2'b00);
        E_EXR   = mk(4'd3,  0,0,0,0,0,0, 2'b00,2'b00, 1,2'b00,3'b010,2'b00);
        E_WBR   = mk(4'd4,  0,0,0,0,0,1, 2'b01,2'b00, 0,2'b00,3'b000,2'b00);
        E_ADDI  = mk(4'd5,  0,0,0,0,0,0, 2'b00,2'b00, 1,2'b10,3'b000,2'b00);
        E_SLTI  = mk(4'd5,  0,0,0,0,0,0, 2'b00,2'b00, 1,2'b10,3'b011,2'b00);
        E_WBI   = mk(4'd6,  0,0,0,0,0,1, 2'b00,2'b00, 0,2'b00,3'b000,2'b00);
        E_MADR  = mk(4'd7,  0,0,0,0,0,0, 2'b00,2'b00, 1,2'b10,3'b000,2'b00);
        E_MRD   = mk(4'd8,  0,0,1,1,0,0, 2'b00,2'b00, 0,2'b00,3'b000,2'b00);
        E_WBLW  = mk(4'd9,  0,0,0,0,0,1, 2'b00,2'b01, 0,2'b00,3'b000,2'b00);
        E_MWR   = mk(4'd10, 0,0,1,0,1,0, 2'b00,2'b00, 0,2'b00,3'b000,2'b00);
        E_BRT   = mk(4'd11, 1,0,0,0,0,0, 2'b00,2'b00, 1,2'b00,3'b001,2'b01);
        E_BRN   = mk(4'd11, 0,0,0,0,0,0, 2'b00,2'b00, 1,2'b00,3'b001,2'b01);
        E_JMP   = mk(4'd12, 1,0,0,0,0,0, 2'b00,2'b00, 0,2'b00,3'b000,2'b10);
        E_JAL   = mk(4'd13, 1,0,0,0,0,1, 2'b10,2'b10, 0,2'b00,3'b000,2'b10);
        E_JR    = mk(4'd14, 1,0,0,0,0,0, 2'b00,2'b00, 0,2'b00,3'b000,2'b11);

        // reset held, then released: R-type add
        cyc("rst_hold",   6'h00, 6'h20, 0, 1, 0, E_IDLE,  0, 0);
        cyc("rst_rel",    6'h00, 6'h20, 0, 1, 1, E_IDLE,  0, 0);
        cyc("add_fetch",  6'h00, 6'h20, 0, 1, 1, E_FETCH, 0, 0);
        cyc("add_dec",    6'h00, 6'h20, 0, 1, 1, E_DEC,   0, 0);
        cyc("add_exe",    6'h00, 6'h20, 0, 1, 1, E_EXR,   0, 0);
        cyc("add_wb",     6'h00, 6'h20, 0, 1, 1, E_WBR,   0, 0);
        // lw with three memory wait states
        cyc("lw_fetch",   6'h23, 6'h00, 0, 1, 1, E_FETCH, 0, 1);
        cyc("lw_dec",     6'h23, 6'h00, 0, 1, 1, E_DEC,   0, 1);
        cyc("lw_adr",     6'h23, 6'h00, 0, 1, 1, E_MADR,  0, 1);
        cyc("lw_rd_w1",   6'h23, 6'h00, 0, 0, 1, E_MRD,   0, 1);
        cyc("lw_rd_w2",   6'h23, 6'h00, 0, 0, 1, E_MRD,   0, 1);
        cyc("lw_rd_w3",   6'h23, 6'h00, 0, 0, 1, E_MRD,   0, 1);
        cyc("lw_rd_ok",   6'h23, 6'h00, 0, 1, 1, E_MRD,   0, 1);
        cyc("lw_wb",      6'h23, 6'h00, 0, 1, 1, E_WBLW,  0, 1);
        // fetch wait state, then beq taken
        cyc("fetch_wait", 6'h04, 6'h00, 1, 0, 1, E_FWAIT, 0, 2);
        cyc("beq1_fetch", 6'h04, 6'h00, 1, 1, 1, E_FETCH, 0, 2);
        cyc("beq1_dec",   6'h04, 6'h00, 1, 1, 1, E_DEC,   0, 2);
        cyc("beq_taken",  6'h04, 6'h00, 1, 1, 1, E_BRT,   0, 2);
        cyc("beq0_fetch", 6'h04, 6'h00, 0, 1, 1, E_FETCH, 0, 3);
        cyc("beq0_dec",   6'h04, 6'h00, 0, 1, 1, E_DEC,   0, 3);
        cyc("beq_not",    6'h04, 6'h00, 0, 1, 1, E_BRN,   0, 3);
        cyc("bne1_fetch", 6'h05, 6'h00, 1, 1, 1, E_FETCH, 0, 4);
        cyc("bne1_dec",   6'h05, 6'h00, 1, 1, 1, E_DEC,   0, 4);
        cyc("bne_not",    6'h05, 6'h00, 1, 1, 1, E_BRN,   0, 4);
        cyc("bne0_fetch", 6'h05, 6'h00, 0, 1, 1, E_FETCH, 0, 5);
        cyc("bne0_dec",   6'h05, 6'h00, 0, 1, 1, E_DEC,   0, 5);
        cyc("bne_taken",  6'h05, 6'h00, 0, 1, 1, E_BRT,   0, 5);
        // jumps
        cyc("jal_fetch",  6'h03, 6'h00, 0, 1, 1, E_FETCH, 0, 6);
        cyc("jal_dec",    6'h03, 6'h00, 0, 1, 1, E_DEC,   0, 6);
        cyc("jal",        6'h03, 6'h00, 0, 1, 1, E_JAL,   0, 6);
        cyc("j_fetch",    6'h02, 6'h00, 0, 1, 1, E_FETCH, 0, 7);
        cyc("j_dec",      6'h02, 6'h00, 0, 1, 1, E_DEC,   0, 7);
        cyc("j",          6'h02, 6'h00, 0, 1, 1, E_JMP,   0, 7);
        cyc("jr_fetch",   6'h00, 6'h08, 0, 1, 1, E_FETCH, 0, 8);
        cyc("jr_dec",     6'h00, 6'h08, 0, 1, 1, E_DEC,   0, 8);
        cyc("jr",         6'h00, 6'h08, 0, 1, 1, E_JR,    0, 8);
        // immediates
        cyc("addi_fetch", 6'h08, 6'h00, 0, 1, 1, E_FETCH, 0, 9);
        cyc("addi_dec",   6'h08, 6'h00, 0, 1, 1, E_DEC,   0, 9);
        cyc("addi_exe",   6'h08, 6'h00, 0, 1, 1, E_ADDI,  0, 9);
        cyc("addi_wb",    6'h08, 6'h00, 0, 1, 1, E_WBI,   0, 9);
        cyc("slti_fetch", 6'h0A, 6'h00, 0, 1, 1, E_FETCH, 0, 10);
        cyc("slti_dec",   6'h0A, 6'h00, 0, 1, 1, E_DEC,   0, 10);
        cyc("slti_exe",   6'h0A, 6'h00, 0, 1, 1, E_SLTI,  0, 10);
        cyc("slti_wb",    6'h0A, 6'h00, 0, 1, 1, E_WBI,   0, 10);
        // illegal opcode: sticky flag, no retire
        cyc("ill_fetch",  6'h3F, 6'h00, 0, 1, 1, E_FETCH, 0, 11);
        cyc("ill_dec",    6'h3F, 6'h00, 0, 1, 1, E_DEC,   0, 11);
        cyc("ill_refetch",6'h2B, 6'h00, 0, 1, 1, E_FETCH, 1, 11);
        // sw stalled, reset pulsed mid-write
        cyc("sw_dec",     6'h2B, 6'h00, 0, 1, 1, E_DEC,   1, 11);
        cyc("sw_adr",     6'h2B, 6'h00, 0, 0, 1, E_MADR,  1, 11);
        cyc("sw_wr_w1",   6'h2B, 6'h00, 0, 0, 1, E_MWR,   1, 11);
        cyc("sw_wr_w2",   6'h2B, 6'h00, 0, 0, 1, E_MWR,   1, 11);
        cyc("async_rst",  6'h2B, 6'h00, 0, 0, 0, E_IDLE,  0, 0);
        cyc("rst_rel2",   6'h2B, 6'h00, 0, 1, 1, E_IDLE,  0, 0);
        cyc("refetch",    6'h2B, 6'h00, 0, 1, 1, E_FETCH, 0, 0);

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
